poly_delay_line: RTL

- Parametrised ring of polynomial buffers for the NewHope pipeline.
- One polynomial is written per pipeline stage into the current write bank; a `shift` pulse rotates the ring.
- Two independent read taps each return the polynomial written a runtime-selectable number of shifts earlier, with per-bank valid tracking.
- Sits between pipeline stages (NTT, sampling, encode) wherever operands must be held across several stages.

---
 rtl/poly_pkg.sv | 22 ++
 rtl/tdp_ram.sv | 48 ++++
 rtl/poly_delay_line.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// ---------------------------------------------------------------------------
// poly_pkg
// Shared constants, types and helpers for the NewHope polynomial datapath.
//   N_COEFF    : coefficients per polynomial
//   COEFF_W    : coefficient width in bits
//   clog2_safe : ceil(log2(v)) clamped to at least 1, safe for port widths
//   coeff_t    : one coefficient
//   caddr_t    : coefficient index within a polynomial
// ---------------------------------------------------------------------------
package poly_pkg;

    localparam int N_COEFF = 1024;
    localparam int COEFF_W = 16;

    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    typedef logic [COEFF_W-1:0]               coeff_t;
    typedef logic [clog2_safe(N_COEFF)-1:0]   caddr_t;

endpackage

// File: rtl/tdp_ram.sv
// ---------------------------------------------------------------------------
// tdp_ram
// True dual-port block RAM holding one polynomial, synchronous read on both
// ports, read-before-write on port A.
//   clk            : clock
//   en_a / we_a    : port A enable / write enable
//   addr_a, din_a  : port A address and write data
//   dout_a         : port A read data (1-cycle latency)
//   en_b, addr_b   : port B enable and address (read only)
//   dout_b         : port B read data (1-cycle latency)
// Contents and read registers are never reset.
// ---------------------------------------------------------------------------
module tdp_ram
    import poly_pkg::*;
#(
    parameter int W = COEFF_W,
    parameter int N = N_COEFF,
    localparam int AW = clog2_safe(N)
) (
    input  logic          clk,
    input  logic          en_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [W-1:0]  din_a,
    output logic [W-1:0]  dout_a,
    input  logic          en_b,
    input  logic [AW-1:0] addr_b,
    output logic [W-1:0]  dout_b
);

    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (en_a) begin
            if (we_a) begin
                mem[addr_a] <= din_a;
            end
            dout_a <= mem[addr_a];
        end
    end

    always_ff @(posedge clk) begin
        if (en_b) begin
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/poly_delay_line.sv
// ---------------------------------------------------------------------------
// poly_delay_line
// Ring of DEPTH+1 polynomial banks. One polynomial is written per pipeline
// stage into the write bank; a shift pulse closes that bank and advances the
// ring. Two read taps return the polynomial written tapk_delay shifts ago.
//   clk, rst            : clock, synchronous active-high reset
//   shift               : close write bank, advance ring
//   flush               : synchronous clear of ring state (same as rst)
//   we, wr_addr, wr_data: write into the current write bank
//   tapk_delay/addr     : tap k delay select (1..DEPTH) and coefficient index
//   tapk_data/valid     : tap k read data and bank-valid flag, 1-cycle latency
//   valid_count         : number of valid banks
//   write_err           : sticky, write hit a bank still marked valid
// ---------------------------------------------------------------------------
module poly_delay_line
    import poly_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int N     = N_COEFF,
    parameter int W     = COEFF_W,
    localparam int AW   = clog2_safe(N),
    localparam int DW   = clog2_safe(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift,
    input  logic          flush,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [DW-1:0] tap0_delay,
    input  logic [AW-1:0] tap0_addr,
    output logic [W-1:0]  tap0_data,
    output logic          tap0_valid,
    input  logic [DW-1:0] tap1_delay,
    input  logic [AW-1:0] tap1_addr,
    output logic [W-1:0]  tap1_data,
    output logic          tap1_valid,
    output logic [DW-1:0] valid_count,
    output logic          write_err
);

    localparam int            NBANK   = DEPTH + 1;
    localparam logic [DW:0]   NBANK_X = (DW+1)'(NBANK);
    localparam logic [DW-1:0] DEPTH_D = DW'(DEPTH);

    function automatic logic tap_legal(input logic [DW-1:0] d);
        return (d != '0) && (d <= DEPTH_D);
    endfunction

    // (ptr - d) mod NBANK without a divider: bias by NBANK, fold once.
    function automatic logic [DW-1:0] src_bank(input logic [DW-1:0] ptr,
                                               input logic [DW-1:0] d);
        logic [DW:0] s;
        s = {1'b0, ptr} + NBANK_X - {1'b0, d};
        if (s >= NBANK_X) begin
            s = s - NBANK_X;
        end
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] popcount(input logic [NBANK-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NBANK; i++) begin
            c += int'(v[i]);
        end
        return DW'(c);
    endfunction

    logic [DW-1:0]    wr_ptr;
    logic [DW-1:0]    wr_ptr_nxt;
    logic [NBANK-1:0] bank_valid;
    logic [NBANK-1:0] bank_valid_nxt;

    logic             legal0;
    logic             legal1;
    logic [DW-1:0]    src0;
    logic [DW-1:0]    src1;

    logic [NBANK-1:0] bank_en_a;
    logic [NBANK-1:0] bank_we_a;
    logic [NBANK-1:0] bank_en_b;
    logic [W-1:0]     dout_a [NBANK];
    logic [W-1:0]     dout_b [NBANK];

    logic             legal0_p1;
    logic             legal1_p1;
    logic [DW-1:0]    src0_p1;
    logic [DW-1:0]    src1_p1;
    logic             vld0_p1;
    logic             vld1_p1;

    // ---- stage p0: address cycle, tap source selection and bank enables ----
    always_comb begin
        legal0 = tap_legal(tap0_delay);
        legal1 = tap_legal(tap1_delay);
        src0   = src_bank(wr_ptr, tap0_delay);
        src1   = src_bank(wr_ptr, tap1_delay);
    end

    always_comb begin
        wr_ptr_nxt     = wr_ptr;
        bank_valid_nxt = bank_valid;
        if (shift) begin
            bank_valid_nxt[wr_ptr]     = 1'b1;
            wr_ptr_nxt                 = (wr_ptr == DEPTH_D) ? '0 : wr_ptr + 1'b1;
            // The bank being entered is reclaimed for the next polynomial.
            bank_valid_nxt[wr_ptr_nxt] = 1'b0;
        end
    end

    // Port A is the write port of the write bank and the tap 1 port of all
    // others; taps can never select the write bank since delay >= 1.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic is_wr;
        assign is_wr        = (wr_ptr == DW'(b));
        assign bank_we_a[b] = is_wr && we;
        assign bank_en_a[b] = (is_wr && we) || (legal1 && (src1 == DW'(b)));
        assign bank_en_b[b] = legal0 && (src0 == DW'(b));

        tdp_ram #(
            .W (W),
            .N (N)
        ) u_ram (
            .clk    (clk),
            .en_a   (bank_en_a[b]),
            .we_a   (bank_we_a[b]),
            .addr_a (is_wr ? wr_addr : tap1_addr),
            .din_a  (wr_data),
            .dout_a (dout_a[b]),
            .en_b   (bank_en_b[b]),
            .addr_b (tap0_addr),
            .dout_b (dout_b[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr      <= '0;
            bank_valid  <= '0;
            valid_count <= '0;
            write_err   <= 1'b0;
            legal0_p1   <= 1'b0;
            legal1_p1   <= 1'b0;
            src0_p1     <= '0;
            src1_p1     <= '0;
            vld0_p1     <= 1'b0;
            vld1_p1     <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            bank_valid  <= bank_valid_nxt;
            valid_count <= popcount(bank_valid_nxt);
            if (we && bank_valid[wr_ptr]) begin
                write_err <= 1'b1;
            end
            // Tap selection is captured from pre-shift state so a shift in
            // the address cycle cannot redirect the returning data.
            legal0_p1   <= legal0;
            legal1_p1   <= legal1;
            src0_p1     <= src0;
            src1_p1     <= src1;
            vld0_p1     <= legal0 && bank_valid[src0];
            vld1_p1     <= legal1 && bank_valid[src1];
        end
    end

    // ---- stage p1: RAM data returns, muxed by the captured source bank ----
    assign tap0_data  = legal0_p1 ? dout_b[src0_p1] : '0;
    assign tap1_data  = legal1_p1 ? dout_a[src1_p1] : '0;
    assign tap0_valid = vld0_p1;
    assign tap1_valid = vld1_p1;

endmodule
